// File: rtl/copro_dispatch.sv
// copro_dispatch: request-side front end for the floating-point coprocessor.
//
// The CPU posts {opcode, op0, op1} commands into a small circular FIFO. A
// single FSM pops one command at a time, issues it to the coprocessor over
// its valid/complete/accept handshake, and returns the result plus an error
// flag on a valid/ready response port. Illegal opcodes are answered with an
// error without touching the coprocessor. A coprocessor that never completes
// is abandoned after TIMEOUT wait cycles.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         command push handshake
//   req_opcode/op0/op1          command fields (opcode 0..3 legal)
//   resp_valid/resp_ready       response handshake
//   resp_result/resp_err        result (0 on error) and error flag
//   busy                        FSM active or commands still queued
//   copro_valid                 one-cycle issue strobe
//   copro_opcode/op0/op1        issued command, held until the next issue
//   copro_complete/result       sticky completion and its result
//   copro_accept                one-cycle acknowledge, idles the coprocessor
module copro_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [10:0] req_opcode,
  input  logic [31:0] req_op0,
  input  logic [31:0] req_op1,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_err,
  output logic        busy,
  output logic        copro_valid,
  output logic [10:0] copro_opcode,
  output logic [31:0] copro_op0,
  output logic [31:0] copro_op1,
  input  logic        copro_complete,
  output logic        copro_accept,
  input  logic [31:0] copro_result
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int CMD_W = 11 + 32 + 32;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [CMD_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  logic             fifo_empty, fifo_full;
  logic [10:0]      head_opcode;
  logic [31:0]      head_op0, head_op1;
  logic             head_legal;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  // Gated by rst_n so that nothing is offered to the CPU while reset is held,
  // even though the state register already sits in INIT.
  assign req_ready  = rst_n && !fifo_full;
  assign push       = req_valid && req_ready;

  assign {head_opcode, head_op0, head_op1} = fifo_mem[rd_ptr];
  assign head_legal = (head_opcode[10:2] == '0);

  // tmo_cnt equals k-1 in the k-th WAIT cycle, so this fires in the
  // TIMEOUT-th cycle spent in WAIT.
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // ---- Command FIFO: storage and pointers ----
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {req_opcode, req_op0, req_op1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- Dispatch FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  // ---- Dispatch FSM: next state and pop decision ----
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_INIT:  state_nxt = S_IDLE;
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = head_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (copro_complete || tmo_hit) state_nxt = S_ACK;
      end
      S_ACK:   state_nxt = S_RESP;
      S_RESP: begin
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  assign copro_valid  = (state == S_ISSUE);
  assign copro_accept = rst_n && ((state == S_INIT) || (state == S_ACK));
  assign resp_valid   = (state == S_RESP);
  assign busy         = (state != S_IDLE) || !fifo_empty;

  // ---- Issue / response datapath ----
  // Only legal pops load the coprocessor-facing registers, so they keep the
  // last issued command across illegal-opcode responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      copro_opcode <= '0;
      copro_op0    <= '0;
      copro_op1    <= '0;
      resp_result  <= '0;
      resp_err     <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      if (pop && head_legal) begin
        copro_opcode <= head_opcode;
        copro_op0    <= head_op0;
        copro_op1    <= head_op1;
      end
      case (state)
        S_IDLE: begin
          if (pop && !head_legal) begin
            resp_result <= '0;
            resp_err    <= 1'b1;
          end
        end
        S_ISSUE: tmo_cnt <= '0;
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          // Completion takes priority over a timeout in the same cycle.
          if (copro_complete) begin
            resp_result <= copro_result;
            resp_err    <= 1'b0;
          end else if (tmo_hit) begin
            resp_result <= '0;
            resp_err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_copro_dispatch.sv
// Testbench for copro_dispatch: directed sequence with randomized operands,
// coprocessor latencies and results, checked against a command-level model
// (expected-response queue in push order plus a behavioural coprocessor).
module tb_copro_dispatch;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [10:0] req_opcode = '0;
  logic [31:0] req_op0 = '0;
  logic [31:0] req_op1 = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;
  logic        resp_err;
  logic        busy;
  logic        copro_valid;
  logic [10:0] copro_opcode;
  logic [31:0] copro_op0;
  logic [31:0] copro_op1;
  logic        copro_complete;
  logic        copro_accept;
  logic [31:0] copro_result;

  copro_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_opcode     (req_opcode),
    .req_op0        (req_op0),
    .req_op1        (req_op1),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_result    (resp_result),
    .resp_err       (resp_err),
    .busy           (busy),
    .copro_valid    (copro_valid),
    .copro_opcode   (copro_opcode),
    .copro_op0      (copro_op0),
    .copro_op1      (copro_op1),
    .copro_complete (copro_complete),
    .copro_accept   (copro_accept),
    .copro_result   (copro_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] opc;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;   // edges from the sampled issue to complete; <0 = never
    logic [31:0] res;
  } iss_t;

  typedef struct {
    logic        err;
    logic [31:0] res;
  } rsp_t;

  iss_t        iss_q[$];   // legal commands still to be issued, in order
  rsp_t        exp_q[$];   // expected responses, in push order
  logic [10:0] last_legal_opc = '0;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural coprocessor plus protocol monitor.
  int          cyc = 0;
  int          n_valid = 0;
  int          n_accept = 0;
  int          mon_bad = 0;
  logic        cp_busy = 1'b0;
  logic        cp_complete = 1'b0;
  int          cp_done_at = -1;
  logic [31:0] cp_res = '0;

  assign copro_complete = cp_complete;
  assign copro_result   = cp_complete ? cp_res : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (copro_valid)  n_valid  <= n_valid + 1;
    if (copro_accept) n_accept <= n_accept + 1;
    if ((copro_valid && copro_accept) ||
        (copro_valid && (cp_busy || cp_complete || (iss_q.size() == 0) ||
                         (copro_opcode !== iss_q[0].opc) ||
                         (copro_op0 !== iss_q[0].a) ||
                         (copro_op1 !== iss_q[0].b))))
      mon_bad <= mon_bad + 1;
    if (copro_accept) begin
      cp_busy     <= 1'b0;
      cp_complete <= 1'b0;
    end else if (copro_valid && (iss_q.size() != 0)) begin
      cp_busy     <= 1'b1;
      cp_complete <= 1'b0;
      cp_res      <= iss_q[0].res;
      cp_done_at  <= (iss_q[0].lat < 0) ? -1 : cyc + iss_q[0].lat;
      void'(iss_q.pop_front());
    end else if (cp_busy && !cp_complete && (cp_done_at == cyc)) begin
      cp_complete <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pushes one command and records what the CPU must get back for it.
  // Completion is seen in WAIT cycle lat+1 and WAIT gives up after TIMEOUT
  // cycles, so lat >= TIMEOUT (or never) ends as a timeout error.
  task automatic push(input logic [10:0] opc, input logic [31:0] a, input logic [31:0] b,
                      input int lat, input logic [31:0] res, output int edge_at);
    bit   ok;
    iss_t ie;
    rsp_t re;
    ok = 1'b0;
    req_valid  = 1'b1;
    req_opcode = opc;
    req_op0    = a;
    req_op1    = b;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("push_ready", 64'(ok), 64'd1);
    if (ok) begin
      if (opc <= 11'd3) begin
        ie.opc = opc; ie.a = a; ie.b = b; ie.lat = lat; ie.res = res;
        iss_q.push_back(ie);
        last_legal_opc = opc;
        re.err = (lat < 0) || (lat >= TIMEOUT);
        re.res = re.err ? 32'h0 : res;
      end else begin
        re.err = 1'b1;
        re.res = 32'h0;
      end
      exp_q.push_back(re);
    end else begin
      req_valid = 1'b0;
    end
    step();
    edge_at   = cyc;
    req_valid = 1'b0;
  endtask

  // Waits for a response, optionally stalls resp_ready, checks it against the
  // head of the expected queue and consumes it.
  task automatic take_resp(input string tag, input int stall, output int t_seen, output int t_done);
    bit   ok;
    rsp_t e;
    ok = 1'b0;
    t_seen = -1;
    t_done = -1;
    for (int i = 0; i < 400; i++) begin
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_valid"}, 64'(ok), 64'd1);
    if (ok) begin
      t_seen = cyc;
      for (int i = 0; i < stall; i++) begin
        step();
        chk({tag, "_stall"}, 64'(resp_valid), 64'd1);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e.err = 1'bx;
        e.res = 'x;
      end
      chk({tag, "_err"}, 64'(resp_err), 64'(e.err));
      chk({tag, "_result"}, 64'(resp_result), 64'(e.res));
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      t_done = cyc;
      chk({tag, "_drop"}, 64'(resp_valid), 64'd0);
    end
  endtask

  initial begin
    int          e_at, t_s, t_d, base_v, base_a, x_prev;
    int          lat_a[5];
    logic [10:0] opc;
    x_prev = 0;

    // Reset held for 3 cycles, then INIT
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_ctrl", 64'({req_ready, resp_valid, resp_err, copro_valid, copro_accept}), 64'd0);
    chk("rst_result", 64'(resp_result), 64'd0);
    chk("rst_copro_opc", 64'(copro_opcode), 64'd0);
    chk("rst_copro_ops", {copro_op0, copro_op1}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    base_a = n_accept;
    rst_n = 1'b1;
    #1;
    chk("init_accept", 64'(copro_accept), 64'd1);
    chk("init_ready", 64'(req_ready), 64'd1);
    chk("init_busy", 64'(busy), 64'd1);
    chk("init_quiet", 64'({copro_valid, resp_valid}), 64'd0);
    step();
    chk("idle_accept", 64'(copro_accept), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    repeat (3) step();
    chk("init_accept_pulses", 64'(n_accept - base_a), 64'd1);

    // Single add: 1.0 + 2.0 = 3.0, coprocessor completes 3 edges after issue
    base_v = n_valid;
    base_a = n_accept;
    push(11'd0, 32'h3F80_0000, 32'h4000_0000, 3, 32'h4040_0000, e_at);
    take_resp("add", 0, t_s, t_d);
    chk("add_latency", 64'(t_s - e_at), 64'(4 + 3));
    chk("add_valid_pulses", 64'(n_valid - base_v), 64'd1);
    chk("add_accept_pulses", 64'(n_accept - base_a), 64'd1);
    chk("add_idle", 64'(busy), 64'd0);

    // Ordering and full: first command pops, the next four fill the FIFO
    resp_ready = 1'b0;
    base_v = n_valid;
    for (int k = 0; k < 5; k++) begin
      lat_a[k] = int'($urandom_range(1, 6));
      push(11'($urandom_range(0, 3)), $urandom, $urandom, lat_a[k], $urandom, e_at);
    end
    chk("full_ready", 64'(req_ready), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    req_valid  = 1'b1;
    req_opcode = 11'd1;
    repeat (20) step();
    req_valid  = 1'b0;
    chk("full_hold_ready", 64'(req_ready), 64'd0);
    chk("full_resp_held", 64'(resp_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      take_resp("ord", 0, t_s, t_d);
      if (k > 0) chk("ord_gap", 64'(t_s - x_prev), 64'(4 + lat_a[k]));
      x_prev = t_d;
      if (k == 0) begin
        chk("full_pop_ready0", 64'(req_ready), 64'd0);
        step();
        chk("full_pop_ready1", 64'(req_ready), 64'd1);
      end
    end
    chk("ord_valid_pulses", 64'(n_valid - base_v), 64'd5);

    // Illegal opcodes never reach the coprocessor
    base_v = n_valid;
    push(11'd7, $urandom, $urandom, 1, 32'h0, e_at);
    take_resp("illegal7", 0, t_s, t_d);
    // The pop edge moves IDLE straight to RESP: one edge after the push edge.
    chk("illegal_latency", 64'(t_s - e_at), 64'd1);
    opc = 11'($urandom_range(4, 2047));
    push(opc, $urandom, $urandom, 1, 32'h0, e_at);
    take_resp("illegal_rand", 2, t_s, t_d);
    chk("illegal_no_issue", 64'(n_valid - base_v), 64'd0);
    chk("illegal_hold_opc", 64'(copro_opcode), 64'(last_legal_opc));
    push(11'd2, $urandom, $urandom, 5, $urandom, e_at);
    take_resp("after_illegal", 0, t_s, t_d);
    chk("after_illegal_latency", 64'(t_s - e_at), 64'(4 + 5));

    // Timeout: never completes, then the completion boundary on both sides
    base_a = n_accept;
    push(11'd1, $urandom, $urandom, -1, 32'h0, e_at);
    take_resp("timeout", 0, t_s, t_d);
    chk("timeout_latency", 64'(t_s - e_at), 64'(3 + TIMEOUT));
    chk("timeout_accept", 64'(n_accept - base_a), 64'd1);
    push(11'd0, $urandom, $urandom, TIMEOUT - 1, $urandom, e_at);
    take_resp("tmo_edge_ok", 0, t_s, t_d);
    chk("tmo_edge_ok_latency", 64'(t_s - e_at), 64'(4 + TIMEOUT - 1));
    push(11'd3, $urandom, $urandom, TIMEOUT, $urandom, e_at);
    take_resp("tmo_edge_late", 0, t_s, t_d);
    push(11'd2, $urandom, $urandom, 2, $urandom, e_at);
    take_resp("after_timeout", 1, t_s, t_d);
    chk("after_timeout_latency", 64'(t_s - e_at), 64'(4 + 2));

    // Random mix of legal/illegal opcodes, latencies and response stalls
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 4) == 0) opc = 11'($urandom_range(4, 2047));
        else                           opc = 11'($urandom_range(0, 3));
        push(opc, $urandom, $urandom, int'($urandom_range(1, TIMEOUT + 4)), $urandom, e_at);
      end
      for (int k = 0; k < 3; k++) take_resp("mix", int'($urandom_range(0, 3)), t_s, t_d);
    end
    chk("mix_idle", 64'(busy), 64'd0);

    // Reset during WAIT drops everything; INIT accept idles the coprocessor
    push(11'd0, $urandom, $urandom, -1, 32'h0, e_at);
    push(11'd1, $urandom, $urandom, 3, $urandom, e_at);
    push(11'd2, $urandom, $urandom, 3, $urandom, e_at);
    repeat (4) step();
    chk("midrst_inflight", 64'(cp_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({req_ready, resp_valid, resp_err, copro_valid, copro_accept}), 64'd0);
    chk("midrst_copro_opc", 64'(copro_opcode), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd1);
    exp_q.delete();
    iss_q.delete();
    repeat (2) step();
    base_v = n_valid;
    base_a = n_accept;
    rst_n = 1'b1;
    #1;
    chk("midrst_init_accept", 64'(copro_accept), 64'd1);
    step();
    chk("midrst_cp_cleared", 64'({cp_busy, cp_complete}), 64'd0);
    repeat (10) step();
    chk("midrst_dropped", 64'({resp_valid, busy}), 64'd0);
    chk("midrst_no_issue", 64'(n_valid - base_v), 64'd0);
    chk("midrst_accept_pulses", 64'(n_accept - base_a), 64'd1);
    push(11'd3, $urandom, $urandom, 4, $urandom, e_at);
    take_resp("after_midrst", 0, t_s, t_d);
    chk("after_midrst_latency", 64'(t_s - e_at), 64'(4 + 4));

    repeat (2) step();
    chk("protocol_monitor", 64'(mon_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
